// File: rtl/csi2_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one CSI-2 TX pipeline among NUM_REQ requesters.
// Grants one frame at a time, enforces an inter-frame gap and a RUN watchdog.
module csi2_tx_frame_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int VC_WIDTH       = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*VC_WIDTH-1:0]  req_vc,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           err_timeout,
  output logic                         frame_start,
  output logic [VC_WIDTH-1:0]          frame_vc,
  output logic                         frame_abort,
  input  logic                         frame_active,
  input  logic                         frame_done,
  output logic                         busy,
  output logic                         spurious_done,
  output logic [1:0]                   state_dbg
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               state, state_d, after_frame;
  logic [PTR_W-1:0]     rr_ptr, rr_d, winner;
  logic                 found;
  logic [NUM_REQ-1:0]   grant_d, ack_d, err_d;
  logic [VC_WIDTH-1:0]  vc_d;
  logic                 start_d, abort_d;
  logic [WD_W-1:0]      wd_cnt, wd_d;
  logic [GAP_W-1:0]     gap_cnt, gap_d;
  logic                 timeout_hit, gap_last;

  // The datapath's streaming flag is informational; nothing here depends on it.
  logic unused_frame_active;
  assign unused_frame_active = frame_active;

  assign after_frame = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign gap_last    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  // Rotating priority search starting at rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    vc_d    = frame_vc;
    rr_d    = rr_ptr;
    start_d = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    abort_d = 1'b0;
    wd_d    = wd_cnt;
    gap_d   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_d = S_START;
          grant_d = NUM_REQ'(1) << winner;
          vc_d    = req_vc[int'(winner)*VC_WIDTH +: VC_WIDTH];
          rr_d    = PTR_W'((int'(winner) + 1) % NUM_REQ);
          start_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        // frame_done takes priority over a watchdog expiry in the same cycle.
        if (frame_done) begin
          ack_d   = grant;
          grant_d = '0;
          gap_d   = '0;
          state_d = after_frame;
        end else if (timeout_hit) begin
          err_d   = grant;
          abort_d = 1'b1;
          grant_d = '0;
          gap_d   = '0;
          state_d = after_frame;
        end else begin
          wd_d = wd_cnt + WD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_last) state_d = S_IDLE;
        else          gap_d   = gap_cnt + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant         <= '0;
      frame_vc      <= '0;
      rr_ptr        <= '0;
      frame_start   <= 1'b0;
      ack           <= '0;
      err_timeout   <= '0;
      frame_abort   <= 1'b0;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
      spurious_done <= 1'b0;
    end else begin
      grant       <= grant_d;
      frame_vc    <= vc_d;
      rr_ptr      <= rr_d;
      frame_start <= start_d;
      ack         <= ack_d;
      err_timeout <= err_d;
      frame_abort <= abort_d;
      wd_cnt      <= wd_d;
      gap_cnt     <= gap_d;
      if (frame_done && state != S_RUN) spurious_done <= 1'b1;
    end
  end

endmodule
